mem_host_port: RTL

- Host-side initiator for the data-memory load/store interface: it drives the address, write data, func3 and write-enable lines that the MEM stage normally drives, and consumes the memory's read data.
- Moves byte streams between an external host link (loader or debug path) and data memory.
- Used to preload filter coefficients and sample windows before the core runs, and to read back results afterwards.
- Write mode packs incoming bytes into SW/SH/SB stores. Read mode issues LW loads and serialises the returned words little-endian.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/mem_host_pack.sv | 54 +++++
 rtl/mem_host_port.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared load/store constants and the host-port state encoding.
package riscv_pkg;

    localparam logic [2:0] F3_B = 3'b000;
    localparam logic [2:0] F3_H = 3'b001;
    localparam logic [2:0] F3_W = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        W_COLLECT,
        W_STORE,
        R_REQ,
        R_WAIT,
        R_SEND,
        DONE
    } state_e;

endpackage

// File: rtl/mem_host_pack.sv
// Four-lane byte pack/unpack register with a lane counter.
// The write path fills lanes on i_push; the read path loads a word and walks lanes on i_pop.
module mem_host_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [7:0]  i_byte,
    input  logic [31:0] i_word,
    output logic [31:0] o_word,
    output logic [2:0]  o_cnt,
    output logic [7:0]  o_byte
);

    logic [31:0] word_q, word_d;
    logic [2:0]  cnt_q, cnt_d;

    always_comb begin
        // NOTE: defaults first so every path assigns word_d/cnt_d and no latch is inferred.
        word_d = word_q;
        cnt_d  = cnt_q;
        if (i_clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (i_load) begin
            word_d = i_word;
            cnt_d  = '0;
        end else if (i_push) begin
            word_d[{cnt_q[1:0], 3'b000} +: 8] = i_byte;
            cnt_d = cnt_q + 3'd1;
        end else if (i_pop) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments; the data word is reset as well
        // so a discarded partial pack can never leak onto the store-data lines.
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_word = word_q;
    assign o_cnt  = cnt_q;
    assign o_byte = word_q[{cnt_q[1:0], 3'b000} +: 8];

endmodule

// File: rtl/mem_host_port.sv
// Host-side initiator on the data-memory load/store port: packs host bytes into
// SW/SH/SB stores, or issues LW loads and streams the words out little-endian.
module mem_host_port
    import riscv_pkg::*;
#(
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1    // load latency, 1 or 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [31:0]      i_base_addr,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_in_valid,
    input  logic [7:0]       i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [7:0]       o_out_data,
    input  logic             i_out_ready,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_data,
    output logic [2:0]       o_mem_func3,
    output logic             o_mem_w_en,
    input  logic [31:0]      i_mem_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic             sub_q, sub_d;
    logic [1:0]       lat_q, lat_d;

    logic        pk_clr, pk_load, pk_push, pk_pop;
    logic [31:0] pk_word;
    logic [2:0]  pk_cnt;
    logic [7:0]  pk_byte;

    mem_host_pack u_pack (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (pk_clr),
        .i_load (pk_load),
        .i_push (pk_push),
        .i_pop  (pk_pop),
        .i_byte (i_in_data),
        .i_word (i_mem_data),
        .o_word (pk_word),
        .o_cnt  (pk_cnt),
        .o_byte (pk_byte)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        sub_d   = sub_q;
        lat_d   = lat_q;
        pk_clr  = 1'b0;
        pk_load = 1'b0;
        pk_push = 1'b0;
        pk_pop  = 1'b0;
        case (state_q)
            IDLE: if (i_start) begin
                pk_clr = 1'b1;
                addr_d = i_base_addr;
                rem_d  = i_len;
                sub_d  = 1'b0;
                if (i_base_addr[1:0] != 2'b00) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    err_d = 1'b0;
                    if (i_len == '0)  state_d = DONE;
                    else if (i_mode)  state_d = R_REQ;
                    else              state_d = W_COLLECT;
                end
            end
            W_COLLECT: if (i_in_valid) begin
                pk_push = 1'b1;
                rem_d   = rem_q - LEN_W'(1);
                if (pk_cnt == 3'd3 || rem_q == LEN_W'(1)) state_d = W_STORE;
            end
            W_STORE: begin
                // a three-byte tail needs a halfword store followed by a byte store
                if (pk_cnt == 3'd3 && !sub_q) begin
                    sub_d = 1'b1;
                end else begin
                    sub_d   = 1'b0;
                    pk_clr  = 1'b1;
                    addr_d  = addr_q + 32'd4;
                    state_d = (rem_q == '0) ? DONE : W_COLLECT;
                end
            end
            R_REQ: begin
                lat_d   = 2'd1;
                state_d = R_WAIT;
            end
            R_WAIT: begin
                if (lat_q == 2'(RD_LAT)) begin
                    pk_load = 1'b1;
                    state_d = R_SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            R_SEND: if (i_out_ready) begin
                pk_pop = 1'b1;
                rem_d  = rem_q - LEN_W'(1);
                if (pk_cnt == 3'd3 || rem_q == LEN_W'(1)) begin
                    addr_d  = addr_q + 32'd4;
                    state_d = (rem_q == LEN_W'(1)) ? DONE : R_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            sub_q   <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            sub_q   <= sub_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_data  = '0;
        o_mem_func3 = F3_B;
        o_mem_w_en  = 1'b0;
        case (state_q)
            W_STORE: begin
                o_mem_w_en = 1'b1;
                o_mem_addr = addr_q;
                case (pk_cnt)
                    3'd4: begin
                        o_mem_func3 = F3_W;
                        o_mem_data  = pk_word;
                    end
                    3'd3: begin
                        if (sub_q) begin
                            o_mem_func3 = F3_B;
                            o_mem_addr  = addr_q + 32'd2;
                            o_mem_data  = {24'h0, pk_word[23:16]};
                        end else begin
                            o_mem_func3 = F3_H;
                            o_mem_data  = {16'h0, pk_word[15:0]};
                        end
                    end
                    3'd2: begin
                        o_mem_func3 = F3_H;
                        o_mem_data  = {16'h0, pk_word[15:0]};
                    end
                    default: begin
                        o_mem_func3 = F3_B;
                        o_mem_data  = {24'h0, pk_word[7:0]};
                    end
                endcase
            end
            R_REQ: begin
                o_mem_addr  = addr_q;
                o_mem_func3 = F3_W;
            end
            default: ;
        endcase
    end

    assign o_in_ready  = (state_q == W_COLLECT);
    assign o_out_valid = (state_q == R_SEND);
    assign o_out_data  = (state_q == R_SEND) ? pk_byte : 8'h00;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_err       = err_q;

endmodule
